// File: rtl/event_encoder_8to3_pkg.sv
// Shared definitions for the event encoder: default width, log2 helper and FSM state encoding.
package enc_pkg;

  localparam int N_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/event_encoder_8to3_if.sv
// Valid/ready index channel from the encoder (master) to the decoder-side consumer (slave).
interface event_encoder_8to3_if #(
  parameter int W = 3
);
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_idx, output out_valid, input out_ready);
  modport slave  (input out_idx, input out_valid, output out_ready);
endinterface

// File: rtl/event_encoder_8to3_prio_enc8.sv
// Combinational priority encoder: index of the highest set bit, plus an any-set flag.
module prio_enc8
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any_set
);

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    idx     = '0;
    any_set = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx     = W'(i);
        any_set = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_encoder_8to3.sv
// Registered priority encoder: sticky pending bits drained highest-first over valid/ready.
//   state    | meaning
//   ST_IDLE  | nothing offered; load the highest pending index when any bit is set
//   ST_OFFER | out_idx offered and held until accepted; reload back-to-back on transfer
module event_encoder_8to3
  import enc_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  event_encoder_8to3_if.master out_if,
  output logic [N-1:0]         pending,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int W = clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [W-1:0]   out_idx_q, out_idx_d;
  logic           overflow_q, overflow_d;

  logic           xfer;
  logic [N-1:0]   clr_mask;
  logic [N-1:0]   remaining;
  logic [N-1:0]   req_in;
  logic [W-1:0]   enc_idx;
  logic           enc_any;

  // Encode only what survives this cycle's clear, so the next offer never repeats the accepted index.
  prio_enc8 #(.N(N), .W(W)) u_prio (
    .vec     (remaining),
    .idx     (enc_idx),
    .any_set (enc_any)
  );

  always_comb begin
    xfer       = (state_q == ST_OFFER) && out_if.out_ready;
    clr_mask   = xfer ? (ONE << out_idx_q) : '0;
    remaining  = pending_q & ~clr_mask;
    req_in     = en ? req : '0;
    pending_d  = remaining | req_in;
    overflow_d = (|(req_in & remaining)) | (overflow_q & ~ovf_clr);
  end

  always_comb begin
    state_d   = state_q;
    out_idx_d = out_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          out_idx_d = enc_idx;
          state_d   = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (xfer) begin
          if (enc_any) out_idx_d = enc_idx;
          else         state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      out_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_idx_q  <= out_idx_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_if.out_idx   = out_idx_q;
  assign out_if.out_valid = (state_q == ST_OFFER);
  assign pending          = pending_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Directed self-checking bench for event_encoder_8to3.
module tb_event_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] pending;
  logic       overflow;
  logic       ovf_clr;
  int         checks;
  int         failures;

  event_encoder_8to3_if #(.W(3)) eif ();

  event_encoder_8to3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .out_if   (eif),
    .pending  (pending),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1; req = 8'h00; ovf_clr = 1'b0; eif.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; req = 8'hFF; ovf_clr = 1'b0; eif.out_ready = 1'b0;
    tick(); tick();
    checks++; if (pending !== 8'h00) begin failures++; $display("FAIL rst_pending got=%h exp=00", pending); end
    checks++; if (eif.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", eif.out_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    rst_n = 1'b1;
    tick();
    req = 8'h00;
    checks++; if (pending !== 8'hFF || eif.out_valid !== 1'b0) begin failures++; $display("FAIL rel_edge1 pend=%h valid=%b exp FF/0", pending, eif.out_valid); end
    tick();
    checks++; if (eif.out_valid !== 1'b1 || eif.out_idx !== 3'd7) begin failures++; $display("FAIL rel_edge2 valid=%b idx=%0d exp 1/7", eif.out_valid, eif.out_idx); end
  endtask

  task automatic test_priority_drain();
    logic [2:0] exp_idx [4];
    exp_idx = '{3'd7, 3'd5, 3'd2, 3'd1};
    do_reset();
    eif.out_ready = 1'b1;
    req = 8'b1010_0110;
    tick();
    req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (eif.out_valid !== 1'b1 || eif.out_idx !== exp_idx[i]) begin failures++; $display("FAIL drain_%0d valid=%b idx=%0d exp 1/%0d", i, eif.out_valid, eif.out_idx, exp_idx[i]); end
    end
    tick();
    checks++; if (eif.out_valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL drain_end valid=%b pend=%h exp 0/00", eif.out_valid, pending); end
  endtask

  task automatic test_stall();
    do_reset();
    req = 8'h01;
    tick();
    req = 8'h00;
    tick();
    for (int c = 1; c <= 5; c++) begin
      req = (c == 3) ? 8'h80 : 8'h00;
      tick();
      checks++; if (eif.out_valid !== 1'b1 || eif.out_idx !== 3'd0) begin failures++; $display("FAIL stall_%0d valid=%b idx=%0d exp 1/0", c, eif.out_valid, eif.out_idx); end
    end
    req = 8'h00;
    checks++; if (pending !== 8'h81) begin failures++; $display("FAIL stall_pend got=%h exp=81", pending); end
    eif.out_ready = 1'b1;
    tick();
    checks++; if (eif.out_valid !== 1'b1 || eif.out_idx !== 3'd7) begin failures++; $display("FAIL stall_next valid=%b idx=%0d exp 1/7", eif.out_valid, eif.out_idx); end
    tick();
    checks++; if (eif.out_valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL stall_end valid=%b pend=%h exp 0/00", eif.out_valid, pending); end
  endtask

  task automatic test_set_wins();
    do_reset();
    req = 8'h10;
    tick();
    req = 8'h00;
    tick();
    checks++; if (eif.out_valid !== 1'b1 || eif.out_idx !== 3'd4) begin failures++; $display("FAIL sw_offer valid=%b idx=%0d exp 1/4", eif.out_valid, eif.out_idx); end
    eif.out_ready = 1'b1;
    req = 8'h10;
    tick();
    req = 8'h00;
    checks++; if (pending !== 8'h10 || overflow !== 1'b0 || eif.out_valid !== 1'b0) begin failures++; $display("FAIL sw_xfer pend=%h ovf=%b valid=%b exp 10/0/0", pending, overflow, eif.out_valid); end
    tick();
    checks++; if (eif.out_valid !== 1'b1 || eif.out_idx !== 3'd4) begin failures++; $display("FAIL sw_reoffer valid=%b idx=%0d exp 1/4", eif.out_valid, eif.out_idx); end
    tick();
    checks++; if (eif.out_valid !== 1'b0 || pending !== 8'h00) begin failures++; $display("FAIL sw_end valid=%b pend=%h exp 0/00", eif.out_valid, pending); end
  endtask

  task automatic test_overflow();
    do_reset();
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    checks++; if (overflow !== 1'b0 || eif.out_idx !== 3'd3) begin failures++; $display("FAIL ovf_pre ovf=%b idx=%0d exp 0/3", overflow, eif.out_idx); end
    req = 8'h08;
    tick();
    req = 8'h00;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    ovf_clr = 1'b1;
    tick();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    req = 8'h08;
    tick();
    req = 8'h00; ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_setwins got=%b exp=1", overflow); end
    tick();
    checks++; if (overflow !== 1'b1 || pending !== 8'h08) begin failures++; $display("FAIL ovf_sticky ovf=%b pend=%h exp 1/08", overflow, pending); end
  endtask

  task automatic test_en_and_async_reset();
    do_reset();
    req = 8'h04;
    tick();
    req = 8'h00;
    tick();
    en = 1'b0; req = 8'hFF;
    tick();
    checks++; if (pending !== 8'h04 || overflow !== 1'b0 || eif.out_idx !== 3'd2) begin failures++; $display("FAIL en_gate pend=%h ovf=%b idx=%0d exp 04/0/2", pending, overflow, eif.out_idx); end
    eif.out_ready = 1'b1;
    tick();
    checks++; if (pending !== 8'h00 || eif.out_valid !== 1'b0) begin failures++; $display("FAIL en_drain pend=%h valid=%b exp 00/0", pending, eif.out_valid); end
    en = 1'b1; req = 8'h00;
    tick();
    checks++; if (eif.out_valid !== 1'b0 || eif.out_idx !== 3'd2) begin failures++; $display("FAIL idle_hold valid=%b idx=%0d exp 0/2", eif.out_valid, eif.out_idx); end
    eif.out_ready = 1'b0;
    req = 8'h40;
    tick();
    req = 8'h00;
    tick();
    checks++; if (eif.out_valid !== 1'b1 || eif.out_idx !== 3'd6) begin failures++; $display("FAIL pre_rst valid=%b idx=%0d exp 1/6", eif.out_valid, eif.out_idx); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (eif.out_valid !== 1'b0 || pending !== 8'h00 || eif.out_idx !== 3'd0) begin failures++; $display("FAIL async_rst valid=%b pend=%h idx=%0d exp 0/00/0", eif.out_valid, pending, eif.out_idx); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_priority_drain();
    test_stall();
    test_set_wins();
    test_overflow();
    test_en_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
